// File: rtl/cpu_ereg.sv
// Decode-to-Execute pipeline register with load-use interlock, branch flush
// and downstream hold handling for the MCS8 pipelined core.
module cpu_ereg #(
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 3,
  parameter int unsigned CW = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          D_VALID_I,
  input  logic [3:0]    D_ICODE_I,
  input  logic [RW-1:0] D_SRCA_I,
  input  logic [RW-1:0] D_SRCB_I,
  input  logic          D_SRCA_CS_I,
  input  logic          D_SRCB_CS_I,
  input  logic [DW-1:0] D_VALA_I,
  input  logic [DW-1:0] D_VALB_I,
  input  logic [RW-1:0] D_DST_I,
  input  logic          D_DSTR_CS_I,
  input  logic          D_DSTR_CS_C_I,
  input  logic          D_DSTR_CS_S_I,
  input  logic          D_DSTR_CS_E_I,
  input  logic          D_DSTR_CS_M_I,
  input  logic [RW-1:0] M_DST_I,
  input  logic          M_VALID_I,
  input  logic          M_DSTR_CS_I,
  input  logic          M_DSTR_CS_M_I,
  input  logic          M_STALL_I,
  input  logic          FLUSH_I,
  output logic          E_VALID_O,
  output logic [3:0]    E_ICODE_O,
  output logic [DW-1:0] E_VALA_O,
  output logic [DW-1:0] E_VALB_O,
  output logic [RW-1:0] E_DST_O,
  output logic          E_DSTR_CS_O,
  output logic          E_DSTR_CS_C_O,
  output logic          E_DSTR_CS_S_O,
  output logic          E_DSTR_CS_E_O,
  output logic          E_DSTR_CS_M_O,
  output logic          D_STALL_O,
  output logic [1:0]    STATE_O,
  output logic [CW-1:0] STALL_CNT_O
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_ILOCK = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FLUSH = 2'b11
  } state_t;

  state_t state;

  logic e_mem_class;
  logic hit_e_a;
  logic hit_e_b;
  logic hit_m_a;
  logic hit_m_b;
  logic ilock;
  logic cnt_sat;

  // Only E/M-class results still in E, or M-class in M, cannot be forwarded.
  assign e_mem_class = E_VALID_O & E_DSTR_CS_O & (E_DSTR_CS_E_O | E_DSTR_CS_M_O);

  assign hit_e_a = D_SRCA_CS_I & e_mem_class & (E_DST_O == D_SRCA_I);
  assign hit_e_b = D_SRCB_CS_I & e_mem_class & (E_DST_O == D_SRCB_I);
  assign hit_m_a = D_SRCA_CS_I & M_VALID_I & M_DSTR_CS_I & M_DSTR_CS_M_I
                 & (M_DST_I == D_SRCA_I);
  assign hit_m_b = D_SRCB_CS_I & M_VALID_I & M_DSTR_CS_I & M_DSTR_CS_M_I
                 & (M_DST_I == D_SRCB_I);

  assign ilock = D_VALID_I & (hit_e_a | hit_e_b | hit_m_a | hit_m_b);

  assign D_STALL_O = RST_I ? 1'b0 : (M_STALL_I | (~FLUSH_I & ilock));

  assign cnt_sat = &STALL_CNT_O;
  assign STATE_O = state;

  // Priority: reset, downstream hold, flush, interlock, normal advance.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state         <= ST_RUN;
      STALL_CNT_O   <= '0;
      E_VALID_O     <= 1'b0;
      E_ICODE_O     <= '0;
      E_VALA_O      <= '0;
      E_VALB_O      <= '0;
      E_DST_O       <= '0;
      E_DSTR_CS_O   <= 1'b0;
      E_DSTR_CS_C_O <= 1'b0;
      E_DSTR_CS_S_O <= 1'b0;
      E_DSTR_CS_E_O <= 1'b0;
      E_DSTR_CS_M_O <= 1'b0;
    end else if (M_STALL_I) begin
      state <= ST_HOLD;
    end else if (FLUSH_I || ilock) begin
      // Bubble: all-zero entry, so it can never produce a hit itself.
      state         <= FLUSH_I ? ST_FLUSH : ST_ILOCK;
      E_VALID_O     <= 1'b0;
      E_ICODE_O     <= '0;
      E_VALA_O      <= '0;
      E_VALB_O      <= '0;
      E_DST_O       <= '0;
      E_DSTR_CS_O   <= 1'b0;
      E_DSTR_CS_C_O <= 1'b0;
      E_DSTR_CS_S_O <= 1'b0;
      E_DSTR_CS_E_O <= 1'b0;
      E_DSTR_CS_M_O <= 1'b0;
      if (!FLUSH_I && !cnt_sat) begin
        STALL_CNT_O <= STALL_CNT_O + CW'(1);
      end
    end else begin
      state         <= ST_RUN;
      E_VALID_O     <= D_VALID_I;
      E_ICODE_O     <= D_ICODE_I;
      E_VALA_O      <= D_VALA_I;
      E_VALB_O      <= D_VALB_I;
      E_DST_O       <= D_DST_I;
      E_DSTR_CS_O   <= D_DSTR_CS_I;
      E_DSTR_CS_C_O <= D_DSTR_CS_C_I;
      E_DSTR_CS_S_O <= D_DSTR_CS_S_I;
      E_DSTR_CS_E_O <= D_DSTR_CS_E_I;
      E_DSTR_CS_M_O <= D_DSTR_CS_M_I;
    end
  end

endmodule
